// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: merges unbuffered ALU results and FIFO-buffered load returns
// into one registered register-file write port, and reports pending destinations.
module riscv_wb_arbiter #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 5,
  parameter int NUM_REGS    = 32,
  parameter int DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [ADDR_LENGTH-1:0] alu_rd,
  input  logic [WORD_LENGTH-1:0] alu_data,
  output logic                   alu_ready,
  input  logic                   ld_valid,
  input  logic [ADDR_LENGTH-1:0] ld_rd,
  input  logic [WORD_LENGTH-1:0] ld_data,
  output logic                   ld_ready,
  output logic                   write_en,
  output logic [ADDR_LENGTH-1:0] write_addr,
  output logic [WORD_LENGTH-1:0] data,
  output logic [NUM_REGS-1:0]    pending_mask
);
  // Valid/ready: a transfer occurs on a rising edge where valid and ready are both
  // high; a stalled source keeps rd/data stable until that edge.

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [ADDR_LENGTH-1:0] fifo_rd_q   [DEPTH];
  logic [WORD_LENGTH-1:0] fifo_data_q [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   we_q, we_d;
  logic [ADDR_LENGTH-1:0] wa_q, wa_d;
  logic [WORD_LENGTH-1:0] wd_q, wd_d;

  logic                   sel_ld, alu_fire, push;
  logic [ADDR_LENGTH-1:0] src_rd;
  logic [WORD_LENGTH-1:0] src_data;
  int                     idx;

  // ALU wins unless the FIFO is full, which guarantees loads make progress.
  always_comb begin
    sel_ld    = (count_q == FULL) | ((count_q != '0) & ~alu_valid);
    alu_ready = ~sel_ld;
    ld_ready  = (count_q < FULL);
    alu_fire  = alu_valid & ~sel_ld;
    push      = ld_valid & ld_ready;
    src_rd    = sel_ld ? fifo_rd_q[rd_ptr_q]   : alu_rd;
    src_data  = sel_ld ? fifo_data_q[rd_ptr_q] : alu_data;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (sel_ld) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({push, sel_ld})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // x0 results are consumed normally but never raise the write enable.
  always_comb begin
    we_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    if (sel_ld | alu_fire) begin
      we_d = (src_rd != '0);
      wa_d = src_rd;
      wd_d = src_data;
    end
  end

  // Occupied entries are the count_q slots starting at the read pointer.
  always_comb begin
    pending_mask = '0;
    idx          = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(count_q)) begin
        idx = int'(rd_ptr_q) + k;
        if (idx >= DEPTH) idx = idx - DEPTH;
        pending_mask[fifo_rd_q[PTR_W'(idx)]] = 1'b1;
      end
    end
    if (we_q) pending_mask[wa_q] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= ld_rd;
      fifo_data_q[wr_ptr_q] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  assign write_en   = we_q;
  assign write_addr = wa_q;
  assign data       = wd_q;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Bench for riscv_wb_arbiter: directed vector table, multi-cycle corner sequences,
// and random traffic checked each cycle against a queue-based reference model.
module tb_riscv_wb_arbiter;
  localparam int W     = 32;
  localparam int A     = 5;
  localparam int NR    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid = 1'b0;
  logic [A-1:0]  alu_rd = '0;
  logic [W-1:0]  alu_data = '0;
  logic          alu_ready;
  logic          ld_valid = 1'b0;
  logic [A-1:0]  ld_rd = '0;
  logic [W-1:0]  ld_data = '0;
  logic          ld_ready;
  logic          write_en;
  logic [A-1:0]  write_addr;
  logic [W-1:0]  wr_data;
  logic [NR-1:0] pending_mask;

  int checks = 0;
  int errors = 0;

  // clock/reset block
  always #5 clk = ~clk;

  riscv_wb_arbiter #(.WORD_LENGTH(W), .ADDR_LENGTH(A), .NUM_REGS(NR), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .write_en(write_en), .write_addr(write_addr), .data(wr_data), .pending_mask(pending_mask)
  );

  // reference model: queued loads as {rd, data}, plus the write-port register
  logic [A+W-1:0] exp_q[$];
  logic           m_we = 1'b0;
  logic [A-1:0]   m_wa = '0;
  logic [W-1:0]   m_wd = '0;
  bit             alu_acc, ld_acc;

  typedef struct {
    logic         av;
    logic [A-1:0] ard;
    logic [W-1:0] ad;
    logic         lv;
    logic [A-1:0] lrd;
    logic [W-1:0] ldd;
    logic         e_ar;
    logic         e_lr;
    logic         e_we;
    logic [A-1:0] e_wa;
    logic [W-1:0] e_wd;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] model_pending();
    logic [NR-1:0] m;
    m = '0;
    foreach (exp_q[i]) m[exp_q[i][A+W-1:W]] = 1'b1;
    if (m_we) m[m_wa] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic logic [A-1:0] rand_rd();
    if ($urandom_range(0, 3) == 0) return '0;
    return A'($urandom_range(1, NR - 1));
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  // One clock: compare every output at the falling edge, advance the model, then
  // return 1ns after the rising edge with the current inputs consumed.
  task automatic tick();
    logic [A+W-1:0] e;
    bit             full, take_ld;
    @(negedge clk);
    full    = (exp_q.size() == DEPTH);
    take_ld = full || (exp_q.size() != 0 && !alu_valid);
    chk("alu_ready", alu_ready, !take_ld);
    chk("ld_ready", ld_ready, !full);
    chk("write_en", write_en, m_we);
    chk("write_addr", write_addr, m_wa);
    chk("data", wr_data, m_wd);
    chk("pending_mask", pending_mask, model_pending());
    ld_acc  = ld_valid && !full;
    alu_acc = alu_valid && !take_ld;
    if (take_ld) begin
      e    = exp_q.pop_front();
      m_we = (e[A+W-1:W] != '0);
      m_wa = e[A+W-1:W];
      m_wd = e[W-1:0];
    end else if (alu_acc) begin
      m_we = (alu_rd != '0);
      m_wa = alu_rd;
      m_wd = alu_data;
    end else begin
      m_we = 1'b0;
    end
    if (ld_acc) exp_q.push_back({ld_rd, ld_data});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [A-1:0] ard, input logic [W-1:0] ad,
                       input logic lv, input logic [A-1:0] lrd, input logic [W-1:0] ldd);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    ld_valid  = lv;
    ld_rd     = lrd;
    ld_data   = ldd;
  endtask

  initial begin
    logic [A-1:0] lrds[3];
    logic [A-1:0] seen[$];
    int           li, alu_n, alu_w;
    bit           stall, block;

    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h1234, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b1, 5'd7, 32'h1234};
    vecs[4] = '{1'b1, 5'd0, 32'h55,       1'b1, 5'd0, 32'h66,   1'b1, 1'b1, 1'b0, 5'd0, 32'h55};
    vecs[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0, 5'd0, 32'h66};
    vecs[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b0, 5'd0, 32'h66};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_write_en", write_en, 1'b0);
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_ld_ready", ld_ready, 1'b1);
    chk("rst_pending", pending_mask, '0);
    rst_n = 1'b1;

    // directed vector table: ALU write, load write two cycles later, x0 from both sources
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ldd);
      #1;
      chk("vec_alu_ready", alu_ready, vecs[i].e_ar);
      chk("vec_ld_ready", ld_ready, vecs[i].e_lr);
      tick();
      chk("vec_write_en", write_en, vecs[i].e_we);
      chk("vec_write_addr", write_addr, vecs[i].e_wa);
      chk("vec_data", wr_data, vecs[i].e_wd);
    end

    // reset with two loads queued and a write on the port
    drive(1'b1, 5'd3, 32'hA3, 1'b1, 5'd11, 32'hB11);
    tick();
    drive(1'b1, 5'd4, 32'hA4, 1'b1, 5'd12, 32'hB12);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    chk("pre_reset_ld_ready", ld_ready, 1'b0);
    chk("pre_reset_write_en", write_en, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_write_en", write_en, 1'b0);
    chk("mid_rst_ld_ready", ld_ready, 1'b1);
    chk("mid_rst_alu_ready", alu_ready, 1'b1);
    chk("mid_rst_pending", pending_mask, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) tick();

    // contention: ALU busy every cycle, three back-to-back loads
    lrds[0] = 5'd8; lrds[1] = 5'd9; lrds[2] = 5'd10;
    li = 0; alu_n = 0; alu_w = 0; stall = 0; block = 0;
    alu_rd = 5'd1;
    alu_data = 32'hC000;
    for (int c = 0; c < 16; c++) begin
      alu_valid = (c < 12);
      ld_valid  = (li < 3);
      if (li < 3) begin
        ld_rd   = lrds[li];
        ld_data = 32'hD000 + W'(li);
      end
      #1;
      if (!ld_ready) stall = 1;
      if (alu_valid && !alu_ready) block = 1;
      tick();
      if (alu_acc) begin
        alu_n++;
        alu_rd   = (alu_rd == 5'd7) ? 5'd1 : alu_rd + 5'd1;
        alu_data = alu_data + 32'd1;
      end
      if (ld_acc) li++;
      if (write_en) begin
        if (write_addr >= 5'd8 && write_addr <= 5'd10) seen.push_back(write_addr);
        else alu_w++;
      end
    end
    ld_valid = 1'b0;
    chk("cont_ld_stall_seen", stall, 1'b1);
    chk("cont_alu_block_seen", block, 1'b1);
    chk("cont_loads_accepted", li, 3);
    chk("cont_alu_writes", alu_w, alu_n);
    chk("cont_load_writes", seen.size(), 3);
    if (seen.size() == 3) begin
      for (int k = 0; k < 3; k++) chk("cont_load_order", seen[k], lrds[k]);
    end

    // push and pop together at count=1, pointers wrap repeatedly
    drive(1'b0, '0, '0, 1'b1, 5'd20, 32'hE000);
    tick();
    for (int i = 0; i < 10; i++) begin
      ld_rd   = 5'd21 + A'(i);
      ld_data = 32'hE001 + W'(i);
      #1;
      chk("pp_ld_ready", ld_ready, 1'b1);
      tick();
      chk("pp_write_addr", write_addr, 5'd20 + A'(i));
      chk("pp_data", wr_data, 32'hE000 + W'(i));
    end
    ld_valid = 1'b0;
    tick();
    chk("pp_last_addr", write_addr, 5'd30);
    chk("pp_last_data", wr_data, 32'hE00A);

    // random traffic, both sources hold until accepted
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    for (int c = 0; c < 400; c++) begin
      if (!alu_valid && $urandom_range(0, 99) < 60) begin
        alu_valid = 1'b1;
        alu_rd    = rand_rd();
        alu_data  = $urandom();
      end
      if (!ld_valid && $urandom_range(0, 99) < 50) begin
        ld_valid = 1'b1;
        ld_rd    = rand_rd();
        ld_data  = $urandom();
      end
      tick();
      if (alu_acc) alu_valid = 1'b0;
      if (ld_acc) ld_valid = 1'b0;
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (4) tick();
    chk("drain_empty_ld_ready", ld_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
